// File: rtl/cpu_if_arbiter_if.sv
// Bridge-side bus of the CPU interface arbiter: the registered request
// towards the cpu_s port of the CDC bridge and the bridge's responses.
// The arbiter uses the master modport, the bridge (or a bench model) the slave.
interface cpu_if_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_s_write;
    logic                  cpu_s_read;
    logic [ADDR_WIDTH-1:0] cpu_s_address;
    logic [DATA_WIDTH-1:0] cpu_s_write_data;
    logic [DATA_WIDTH-1:0] cpu_s_read_data;
    logic                  cpu_s_access_ready;
    logic                  cpu_s_access_complete;

    modport master (
        output cpu_s_write, cpu_s_read, cpu_s_address, cpu_s_write_data,
        input  cpu_s_read_data, cpu_s_access_ready, cpu_s_access_complete
    );

    modport slave (
        input  cpu_s_write, cpu_s_read, cpu_s_address, cpu_s_write_data,
        output cpu_s_read_data, cpu_s_access_ready, cpu_s_access_complete
    );
endinterface

// File: rtl/cpu_if_arbiter.sv
// Round-robin arbiter sharing one cpu_s port of the CPU interface CDC bridge
// between NUM_REQ local requesters, one outstanding access at a time.
// Optional feature macro: CPU_IF_ARB_TIMEOUT_EN adds a WAIT-state timeout
// with an error-qualified completion and swallowing of late completions.
module cpu_if_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          cpu_s_clk,
    input  logic                          cpu_s_reset_n,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            req_access_ready,
    output logic [NUM_REQ-1:0]            req_access_complete,
    output logic [DATA_WIDTH-1:0]         req_read_data,
    output logic                          req_access_error,
    output logic                          busy,
    cpu_if_arbiter_if.master              cpu_s
);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cpu_if_arbiter: parameter out of range");
    end

    logic [1:0]            state_q, state_d;
    logic [RW-1:0]         ptr_q, ptr_d;
    logic [RW-1:0]         grant_q, grant_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]    req_any_vec;
    logic                  req_any;
    logic [RW-1:0]         pick;
    logic [RW-1:0]         grant_nxt;

    // Completion that really belongs to the current access, timeout event,
    // and permission to start a new grant.
    logic                  cmpl_live;
    logic                  timeout_hit;
    logic                  grant_ok;

    assign req_any_vec = req_write | req_read;
    assign req_any     = |req_any_vec;
    assign grant_nxt   = (grant_q == RW'(NUM_REQ - 1)) ? '0 : grant_q + RW'(1);

    // Pick the first requester at or after the round-robin pointer; scanning
    // from the far end lets the closest index overwrite the others.
    always_comb begin
        pick = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req_any_vec[idx]) begin
                pick = RW'(idx);
            end
        end
    end

`ifdef CPU_IF_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]  stale_q, stale_d;

    assign cmpl_live   = cpu_s.cpu_s_access_complete && (stale_q == 4'd0);
    assign timeout_hit = (state_q == ST_WAIT) && !cmpl_live &&
                         (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign grant_ok    = (stale_q == 4'd0);

    // Wait counter restarts while issuing, counts WAIT cycles; stale counts
    // abandoned accesses whose completion the bridge still owes us.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        stale_d    = stale_q;
        if (state_q == ST_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
        if (timeout_hit) begin
            if (stale_q != 4'hF) begin
                stale_d = stale_q + 4'd1;
            end
        end else if (cpu_s.cpu_s_access_complete && stale_q != 4'd0) begin
            stale_d = stale_q - 4'd1;
        end
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge cpu_s_clk or negedge cpu_s_reset_n) begin
        if (!cpu_s_reset_n) begin
            wait_cnt_q <= '0;
            stale_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            stale_q    <= stale_d;
        end
    end

    assign req_access_error = timeout_hit;
    assign req_read_data    = timeout_hit ? '0 : cpu_s.cpu_s_read_data;
`else
    assign cmpl_live        = cpu_s.cpu_s_access_complete;
    assign timeout_hit      = 1'b0;
    assign grant_ok         = 1'b1;
    assign req_access_error = 1'b0;
    assign req_read_data    = cpu_s.cpu_s_read_data;
`endif

    // Next-state logic of the IDLE -> ISSUE -> WAIT access sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any && grant_ok) begin
                    grant_d = pick;
                    wr_d    = req_write[pick];
                    rd_d    = !req_write[pick];
                    addr_d  = req_address[int'(pick) * ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_write_data[int'(pick) * DATA_WIDTH +: DATA_WIDTH];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cpu_s.cpu_s_access_ready) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmpl_live || timeout_hit) begin
                    ptr_d   = grant_nxt;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, grant and captured request registers.
    always_ff @(posedge cpu_s_clk or negedge cpu_s_reset_n) begin
        if (!cpu_s_reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Route bridge ready/complete pulses to the granted requester only.
    always_comb begin
        req_access_ready    = '0;
        req_access_complete = '0;
        if (state_q == ST_ISSUE && cpu_s.cpu_s_access_ready) begin
            req_access_ready[grant_q] = 1'b1;
        end
        if (state_q == ST_WAIT && (cmpl_live || timeout_hit)) begin
            req_access_complete[grant_q] = 1'b1;
        end
    end

    assign busy                   = (state_q != ST_IDLE);
    assign cpu_s.cpu_s_write      = wr_q;
    assign cpu_s.cpu_s_read       = rd_q;
    assign cpu_s.cpu_s_address    = addr_q;
    assign cpu_s.cpu_s_write_data = wdata_q;
endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Scoreboard bench for cpu_if_arbiter: directed requests feed per-requester
// driver processes, expected bridge issues / ready / complete pulses are
// queued up front and popped by a monitor whenever the DUT shows them.
module tb_cpu_if_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int          idx;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } job_t;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } iss_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          err;
        bit          chkd;
    } cmp_t;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_write;
    logic [NR-1:0]      req_read;
    logic [NR*AW-1:0]   req_address;
    logic [NR*DW-1:0]   req_write_data;
    logic [NR-1:0]      req_access_ready;
    logic [NR-1:0]      req_access_complete;
    logic [DW-1:0]      req_read_data;
    logic               req_access_error;
    logic               busy;

    cpu_if_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cpu_if_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .cpu_s_clk          (clk),
        .cpu_s_reset_n      (rst_n),
        .req_write          (req_write),
        .req_read           (req_read),
        .req_address        (req_address),
        .req_write_data     (req_write_data),
        .req_access_ready   (req_access_ready),
        .req_access_complete(req_access_complete),
        .req_read_data      (req_read_data),
        .req_access_error   (req_access_error),
        .busy               (busy),
        .cpu_s              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    job_t jq[$];
    iss_t iss_q[$];
    int   rdy_q[$];
    cmp_t cmp_q[$];

    bit          auto_bridge = 1'b1;
    int          rdy_dly = 3;
    int          cmp_dly = 5;
    logic [31:0] bridge_rdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    task automatic push_iss(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        iss_t e;
        e.wr = wr; e.rd = rd; e.addr = a; e.data = d;
        iss_q.push_back(e);
    endtask

    task automatic push_cmp(input int idx, input logic [31:0] d, input bit err, input bit chkd);
        cmp_t e;
        e.idx = idx; e.data = d; e.err = err; e.chkd = chkd;
        cmp_q.push_back(e);
    endtask

    // Full expected access: bridge issue, ready to idx, complete to idx.
    task automatic expect_acc(input int idx, input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input bit chkd, input logic [31:0] rdat);
        push_iss(wr, rd, a, d);
        rdy_q.push_back(idx);
        push_cmp(idx, rdat, 1'b0, chkd);
    endtask

    task automatic add_job(input int idx, input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d);
        job_t j;
        j.idx = idx; j.wr = wr; j.rd = rd; j.addr = a; j.data = d;
        jq.push_back(j);
    endtask

    task automatic requester(input int i);
        job_t j;
        bit   found;
        int   n;
        @(posedge clk); #1;
        forever begin
            found = 1'b0;
            for (int k = 0; k < jq.size(); k++) begin
                if (jq[k].idx == i) begin
                    j = jq[k];
                    jq.delete(k);
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                @(posedge clk); #1;
            end else begin
                req_write[i] = j.wr;
                req_read[i]  = j.rd;
                req_address[i*AW +: AW]    = j.addr;
                req_write_data[i*DW +: DW] = j.data;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!req_access_ready[i] && n < 300);
                if (!req_access_ready[i]) flag("req_ready_timeout", 64'(i));
                @(posedge clk); #1;
                req_write[i] = 1'b0;
                req_read[i]  = 1'b0;
            end
        end
    endtask

    task automatic bridge();
        forever begin
            @(negedge clk);
            if (auto_bridge && (bus.cpu_s_write || bus.cpu_s_read)) begin
                repeat (rdy_dly) @(posedge clk);
                #1 bus.cpu_s_access_ready = 1'b1;
                @(posedge clk);
                #1 bus.cpu_s_access_ready = 1'b0;
                repeat (cmp_dly - 1) begin
                    @(posedge clk); #1;
                end
                bus.cpu_s_read_data       = bridge_rdata;
                bus.cpu_s_access_complete = 1'b1;
                @(posedge clk);
                #1 bus.cpu_s_access_complete = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        iss_t ei;
        cmp_t ec;
        int   er;
        bit   iss, iss_prev;
        iss_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (|req_access_ready) begin
                if (rdy_q.size() == 0) flag("ready_extra", 64'(req_access_ready));
                else begin
                    er = rdy_q.pop_front();
                    chk("ready_vec", 64'(req_access_ready), 64'(1) << er);
                end
            end
            if (|req_access_complete) begin
                if (cmp_q.size() == 0) flag("complete_extra", 64'(req_access_complete));
                else begin
                    ec = cmp_q.pop_front();
                    chk("complete_vec", 64'(req_access_complete), 64'(1) << ec.idx);
                    chk("complete_err", 64'(req_access_error), 64'(ec.err));
                    if (ec.chkd) chk("read_data", 64'(req_read_data), 64'(ec.data));
                end
            end
            iss = bus.cpu_s_write || bus.cpu_s_read;
            if (iss && !iss_prev) begin
                if (iss_q.size() == 0) flag("issue_extra", 64'(bus.cpu_s_address));
                else begin
                    ei = iss_q.pop_front();
                    chk("issue_op", {62'd0, bus.cpu_s_write, bus.cpu_s_read}, {62'd0, ei.wr, ei.rd});
                    chk("issue_addr", 64'(bus.cpu_s_address), 64'(ei.addr));
                    chk("issue_wdata", 64'(bus.cpu_s_write_data), 64'(ei.data));
                end
            end
            iss_prev = iss;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((iss_q.size() != 0 || rdy_q.size() != 0 || cmp_q.size() != 0 ||
                jq.size() != 0 || busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) flag("drain_timeout", 64'(busy));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},     64'(busy), 64'd0);
        chk({tag, "_wr"},       64'(bus.cpu_s_write), 64'd0);
        chk({tag, "_rd"},       64'(bus.cpu_s_read), 64'd0);
        chk({tag, "_addr"},     64'(bus.cpu_s_address), 64'd0);
        chk({tag, "_wdata"},    64'(bus.cpu_s_write_data), 64'd0);
        chk({tag, "_ready"},    64'(req_access_ready), 64'd0);
        chk({tag, "_complete"}, 64'(req_access_complete), 64'd0);
        chk({tag, "_error"},    64'(req_access_error), 64'd0);
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.cpu_s_write || bus.cpu_s_read) && n < 20);
        if (!(bus.cpu_s_write || bus.cpu_s_read)) flag(name, 64'(n));
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        req_write = '0;
        req_read = '0;
        req_address = '0;
        req_write_data = '0;
        bus.cpu_s_read_data = '0;
        bus.cpu_s_access_ready = 1'b0;
        bus.cpu_s_access_complete = 1'b0;

        fork
            requester(0);
            requester(1);
            requester(2);
            requester(3);
            bridge();
            monitor();
            begin
                repeat (30000) @(posedge clk);
                $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
                $fatal(1, "watchdog expired");
            end
        join_none

        #1 chk_reset("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write from requester 2 with 3/5-cycle bridge delays.
        bridge_rdata = 32'h5555_0000;
        expect_acc(2, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, 1'b0, 32'h0);
        @(negedge clk);
        add_job(2, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_write[2] && n < 10);
        chk("t1_wr_same_cycle", 64'(bus.cpu_s_write), 64'd0);
        @(negedge clk);
        chk("t1_wr_next_cycle", 64'(bus.cpu_s_write), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        drain();

        // Read from requester 0 with the fastest bridge.
        rdy_dly = 1;
        cmp_dly = 1;
        bridge_rdata = 32'h12345678;
        expect_acc(0, 1'b0, 1'b1, 32'h2000, 32'h0, 1'b1, 32'h12345678);
        @(negedge clk);
        add_job(0, 1'b0, 1'b1, 32'h2000, 32'h0);
        drain();

        // Fairness from reset: all four request, order 0,1,2,3,0.
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        rdy_dly = 3;
        cmp_dly = 2;
        bridge_rdata = 32'hCAFEF00D;
        expect_acc(0, 1'b0, 1'b1, 32'h0100, 32'h0,  1'b1, 32'hCAFEF00D);
        expect_acc(1, 1'b1, 1'b0, 32'h0110, 32'h11, 1'b0, 32'h0);
        expect_acc(2, 1'b0, 1'b1, 32'h0120, 32'h0,  1'b1, 32'hCAFEF00D);
        expect_acc(3, 1'b1, 1'b0, 32'h0130, 32'h33, 1'b0, 32'h0);
        expect_acc(0, 1'b1, 1'b0, 32'h0140, 32'h44, 1'b0, 32'h0);
        @(negedge clk);
        add_job(0, 1'b0, 1'b1, 32'h0100, 32'h0);
        add_job(1, 1'b1, 1'b0, 32'h0110, 32'h11);
        add_job(2, 1'b0, 1'b1, 32'h0120, 32'h0);
        add_job(3, 1'b1, 1'b0, 32'h0130, 32'h33);
        add_job(0, 1'b1, 1'b0, 32'h0140, 32'h44);
        drain();

        // Write wins over read; spurious ready in IDLE and complete in ISSUE.
        auto_bridge = 1'b0;
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b1;
        @(negedge clk);
        chk("t4_spur_ready", 64'(req_access_ready), 64'd0);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b0;
        bus.cpu_s_read_data = 32'h0;
        expect_acc(1, 1'b1, 1'b0, 32'h0800, 32'h0BADBEEF, 1'b0, 32'h0);
        @(negedge clk);
        add_job(1, 1'b1, 1'b1, 32'h0800, 32'h0BADBEEF);
        wait_issue("t4_issue_timeout");
        @(posedge clk);
        #1 bus.cpu_s_access_complete = 1'b1;
        @(negedge clk);
        chk("t4_spur_complete", 64'(req_access_complete), 64'd0);
        chk("t4_wr_held", 64'(bus.cpu_s_write), 64'd1);
        @(posedge clk);
        #1 bus.cpu_s_access_complete = 1'b0;
        bus.cpu_s_access_ready = 1'b1;
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b0;
        @(posedge clk);
        #1 bus.cpu_s_access_complete = 1'b1;
        @(posedge clk);
        #1 bus.cpu_s_access_complete = 1'b0;
        drain();

        // Reset while waiting for completion; requester 0 wins afterwards.
        push_iss(1'b0, 1'b1, 32'h3000, 32'h0);
        rdy_q.push_back(3);
        @(negedge clk);
        add_job(3, 1'b0, 1'b1, 32'h3000, 32'h0);
        wait_issue("t5_issue_timeout");
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b1;
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b0;
        @(negedge clk);
        chk("t5_busy_wait", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        bus.cpu_s_access_complete = 1'b1;
        #1 chk_reset("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        bus.cpu_s_access_complete = 1'b0;
        auto_bridge = 1'b1;
        bridge_rdata = 32'h0F0F1234;
        expect_acc(0, 1'b0, 1'b1, 32'h4000, 32'h0,  1'b1, 32'h0F0F1234);
        expect_acc(2, 1'b1, 1'b0, 32'h5000, 32'h55, 1'b0, 32'h0);
        @(negedge clk);
        add_job(0, 1'b0, 1'b1, 32'h4000, 32'h0);
        add_job(2, 1'b1, 1'b0, 32'h5000, 32'h55);
        drain();

`ifdef CPU_IF_ARB_TIMEOUT_EN
        // Timeout after 16 WAIT cycles, late completion swallowed, grant held off.
        auto_bridge = 1'b0;
        bus.cpu_s_read_data = 32'hFFFFFFFF;
        push_iss(1'b0, 1'b1, 32'h6000, 32'h0);
        rdy_q.push_back(1);
        push_cmp(1, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        add_job(1, 1'b0, 1'b1, 32'h6000, 32'h0);
        wait_issue("t6_issue_timeout");
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b1;
        @(posedge clk);
        #1 bus.cpu_s_access_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(|req_access_complete) && n < 40);
        chk("t6_timeout_cycle", 64'(n), 64'd16);
        expect_acc(2, 1'b1, 1'b0, 32'h7000, 32'h77, 1'b0, 32'h0);
        @(negedge clk);
        add_job(2, 1'b1, 1'b0, 32'h7000, 32'h77);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.cpu_s_write;
        end
        chk("t6_stale_blocks_grant", 64'(seen), 64'd0);
        @(posedge clk);
        #1 bus.cpu_s_read_data = 32'hDEADBEEF;
        bus.cpu_s_access_complete = 1'b1;
        @(negedge clk);
        chk("t6_late_swallowed", 64'(req_access_complete), 64'd0);
        @(posedge clk);
        #1 bus.cpu_s_access_complete = 1'b0;
        auto_bridge = 1'b1;
        drain();
`endif

        chk("left_issue", 64'(iss_q.size()), 64'd0);
        chk("left_ready", 64'(rdy_q.size()), 64'd0);
        chk("left_complete", 64'(cmp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
